// File: rtl/z80_int_ctl.sv
// Prioritised IM2 interrupt controller for the Z80 bus: edge-detected requests, mask/EOI ports, vectored acknowledge.
// Optional Z80_INT_CTL_STATUS_READ_EN: I/O read at IO_BASE returns {in_service, pending}.
module z80_int_ctl #(
  parameter int          NUM_SRC  = 4,
  parameter logic [7:0]  IO_BASE  = 8'h40,
  parameter logic [7:0]  VEC_BASE = 8'hE0
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [7:0]         A,
  input  logic [7:0]         D_in,
  output logic [7:0]         D_out,
  output logic               D_oe,
  input  logic               nM1,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  output logic               nINT
);

  localparam int         IW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [7:0] EOI_ADDR = IO_BASE + 8'd1;

  typedef enum logic [1:0] {IDLE, REQ, ACK, SERV} state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] irq_d, irq_q, pending, mask, elig, rise, clr;
  logic [IW-1:0]      win_idx, win_q;
  logic               inta, iow, iow_q, iow_rise, eoi, ack_go, spur_n, spur_q;
  logic               unused_bits;

  assign unused_bits = ^{D_in, nRD};

  assign inta     = !nM1 && !nIORQ;
  assign iow      = !nIORQ && !nWR && nM1;
  assign iow_rise = iow && !iow_q;
  assign eoi      = iow_rise && (A == EOI_ADDR);

  // irq passes a history stage before the edge compare, giving the 3-edge request latency
  assign rise = irq_d & ~irq_q;
  assign elig = pending & ~mask;

  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) win_idx = IW'(i);
  end

  assign ack_go = (state == REQ) && inta && (elig != '0);
  assign clr    = ack_go ? (NUM_SRC'(1) << win_idx) : '0;
  assign spur_n = inta && ((state_n == IDLE) || (state_n == SERV));

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (!inta && elig != '0) state_n = REQ;
      REQ: begin
        if (ack_go)              state_n = ACK;
        else if (elig == '0)     state_n = IDLE;
      end
      ACK:  if (nIORQ) state_n = SERV;
      SERV: if (eoi)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      irq_d   <= '0;
      irq_q   <= '0;
      pending <= '0;
      mask    <= '1;
      win_q   <= '0;
      iow_q   <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      irq_d   <= irq;
      irq_q   <= irq_d;
      // a new edge on the bit being acknowledged must not be lost
      pending <= (pending & ~clr) | rise;
      iow_q   <= iow;
      spur_q  <= spur_n;
      if (iow_rise && A == IO_BASE) mask <= D_in[NUM_SRC-1:0];
      if (ack_go) win_q <= win_idx;
    end
  end

`ifdef Z80_INT_CTL_STATUS_READ_EN
  logic       io_rd;
  logic [7:0] status;
  assign io_rd  = !nIORQ && !nRD && nM1 && (A == IO_BASE);
  assign status = {(state == SERV), 7'(pending)};
`endif

  always_comb begin
    nINT  = (state != REQ);
    D_oe  = 1'b0;
    D_out = 8'h00;
    if (state == ACK) begin
      D_oe  = 1'b1;
      D_out = VEC_BASE | 8'({win_q, 1'b0});
    end else if (spur_q) begin
      D_oe  = 1'b1;
      D_out = 8'hFF;
    end
`ifdef Z80_INT_CTL_STATUS_READ_EN
    else if (io_rd) begin
      D_oe  = 1'b1;
      D_out = status;
    end
`endif
  end

endmodule

// File: tb/tb_z80_int_ctl.sv
// Directed bench for z80_int_ctl: per-cycle vector table plus hand sequences for reset-in-ACK and status read.
module tb_z80_int_ctl;

  logic       CLK = 1'b0, nRESET = 1'b0;
  logic [3:0] irq = '0;
  logic [7:0] A = '0, D_in = '0, D_out;
  logic       D_oe, nM1 = 1'b1, nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nINT;

  z80_int_ctl #(.NUM_SRC(4), .IO_BASE(8'h40), .VEC_BASE(8'hE0)) dut (
    .CLK(CLK), .nRESET(nRESET), .irq(irq), .A(A), .D_in(D_in), .D_out(D_out),
    .D_oe(D_oe), .nM1(nM1), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nINT(nINT)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [1:0] {NOP, WR, INTA, RD} op_e;
  typedef struct {
    logic [3:0] irq;
    op_e        op;
    logic [7:0] a, d;
    logic       nint, oe;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0, n_fail = 0;

  task automatic add(input logic [3:0] i, input op_e op, input logic [7:0] a, input logic [7:0] d,
                     input logic nint, input logic oe, input logic [7:0] dout);
    vec_t v;
    v.irq = i; v.op = op; v.a = a; v.d = d; v.nint = nint; v.oe = oe; v.dout = dout;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [3:0] i, input op_e op, input logic [7:0] a, input logic [7:0] d);
    irq = i; A = a; D_in = d;
    nM1 = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    case (op)
      WR:   begin nIORQ = 1'b0; nWR = 1'b0; end
      INTA: begin nM1 = 1'b0; nIORQ = 1'b0; end
      RD:   begin nIORQ = 1'b0; nRD = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic step(input logic [3:0] i, input op_e op, input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    drive(i, op, a, d);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int idx, input logic nint, input logic oe, input logic [7:0] dout);
    chk({name, ".nINT"}, idx, {7'd0, nINT}, {7'd0, nint});
    chk({name, ".D_oe"}, idx, {7'd0, D_oe}, {7'd0, oe});
    chk({name, ".D_out"}, idx, D_out, dout);
  endtask

  initial begin
    // single source through the full handshake
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h40, 8'h00, 1, 0, 8'h00);
    add(4'h4, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE4);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE4);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h41, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    // simultaneous irq[3] and irq[1]: priority then re-arbitration after EOI
    add(4'hA, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'hA, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE2);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h41, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE6);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h41, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    // masked request released by a mask write
    add(4'h0, WR,   8'h40, 8'h01, 1, 0, 8'h00);
    add(4'h1, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h40, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE0);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h41, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    // masked while in REQ, spurious acknowledge, pending kept
    add(4'h2, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, WR,   8'h40, 8'h02, 0, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hFF);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hFF);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h40, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE2);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h41, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    // new edge on the acknowledged bit in the acknowledge cycle survives
    add(4'h4, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h4, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE4);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h41, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE4);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    // request during SERV waits for EOI, then ends parked in ACK
    add(4'h1, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 1, 0, 8'h00);
    add(4'h0, WR,   8'h41, 8'h00, 1, 0, 8'h00);
    add(4'h0, NOP,  8'h00, 8'h00, 0, 0, 8'h00);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE0);
    add(4'h0, INTA, 8'h00, 8'h00, 1, 1, 8'hE0);

    #2;
    chk_out("reset", 0, 1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    nRESET = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].irq, tbl[k].op, tbl[k].a, tbl[k].d);
      chk_out("vec", k, tbl[k].nint, tbl[k].oe, tbl[k].dout);
    end

    // asynchronous reset while ACK is driving the bus
    @(negedge CLK);
    nRESET = 1'b0;
    #1;
    chk_out("rst_in_ack", 0, 1'b1, 1'b0, 8'h00);
    drive(4'h0, NOP, 8'h00, 8'h00);
    @(negedge CLK);
    nRESET = 1'b1;

`ifdef Z80_INT_CTL_STATUS_READ_EN
    @(negedge CLK);
    drive(4'h0, RD, 8'h40, 8'h00);
    #1;
    chk_out("status_after_rst", 0, 1'b1, 1'b1, 8'h00);
    drive(4'h0, NOP, 8'h00, 8'h00);
`endif

    // mask came back all ones: pending irq[0] must not raise nINT
    step(4'h1, NOP, 8'h00, 8'h00);
    step(4'h0, NOP, 8'h00, 8'h00);
    step(4'h0, NOP, 8'h00, 8'h00);
    step(4'h0, NOP, 8'h00, 8'h00);
    chk_out("masked_after_rst", 0, 1'b1, 1'b0, 8'h00);

`ifdef Z80_INT_CTL_STATUS_READ_EN
    @(negedge CLK);
    drive(4'h0, RD, 8'h40, 8'h00);
    #1;
    chk_out("status_pending", 0, 1'b1, 1'b1, 8'h01);
    drive(4'h0, NOP, 8'h00, 8'h00);
`endif

    step(4'h0, WR, 8'h40, 8'h00);
    chk_out("unmask_after_rst", 0, 1'b1, 1'b0, 8'h00);
    step(4'h0, NOP, 8'h00, 8'h00);
    chk_out("unmask_after_rst", 1, 1'b0, 1'b0, 8'h00);
    step(4'h0, INTA, 8'h00, 8'h00);
    chk_out("ack_after_rst", 0, 1'b1, 1'b1, 8'hE0);
    step(4'h0, NOP, 8'h00, 8'h00);
    chk_out("serv_after_rst", 0, 1'b1, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
